// File: rtl/router_pkg.sv
// Shared constants, state encoding and header helper for the router packet transmitter.
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 2;
    localparam int CNT_W   = DATA_W - ADDR_W;
    localparam int MAX_LEN = (1 << CNT_W) - 1;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2,
        PAR  = 2'd3
    } tx_state_t;

    // Header layout: payload length in the upper bits, destination port in the lower bits.
    function automatic logic [DATA_W-1:0] build_header(input logic [CNT_W-1:0]  len,
                                                       input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload register file for router_pkt_tx: write counter doubles as write pointer,
// combinational read at the transmitter's read pointer.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [CNT_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [MAX_LEN];
    logic              push;

    assign full = (count == CNT_W'(MAX_LEN));
    assign push = wr_en && !full;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push) begin
            count <= count + CNT_W'(1);
        end
    end

    // Contents need no reset; only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[count] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: header, buffered payload, then parity, stalling on busy.
// Optional build macro ROUTER_TX_ERR_INJECT_EN adds err_inject to send inverted parity.
//
// state | meaning
// IDLE  | waiting for start; payload buffer writable
// HDR   | header byte on data_out
// PLD   | payload byte on data_out
// PAR   | parity byte on data_out, pkt_valid low
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  buf_count,
    output logic              buf_full,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              tx_busy,
    output logic              done,
    output logic              cmd_err,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out
);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              pkt_valid_nxt;
    logic [DATA_W-1:0] parity, parity_nxt;
    logic [CNT_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  len, len_nxt;
    logic              inj, inj_nxt;
    logic              done_nxt;
    logic              cmd_err_nxt;
    logic              buf_wr;
    logic              buf_clr;
    logic [DATA_W-1:0] buf_rd_data;
    logic [DATA_W-1:0] header;

    // A start in the same cycle as wr_en takes priority; the write is dropped.
    assign buf_wr  = wr_en && (state == IDLE) && !start;
    assign tx_busy = (state != IDLE);
    assign header  = build_header(buf_count, addr);

    router_tx_buf u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (buf_wr),
        .wr_data (wr_data),
        .clr     (buf_clr),
        .rd_ptr  (rd_ptr),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (buf_full)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            parity    <= '0;
            rd_ptr    <= '0;
            len       <= '0;
            inj       <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_out  <= data_nxt;
            pkt_valid <= pkt_valid_nxt;
            parity    <= parity_nxt;
            rd_ptr    <= rd_ptr_nxt;
            len       <= len_nxt;
            inj       <= inj_nxt;
            done      <= done_nxt;
            cmd_err   <= cmd_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_nxt      = data_out;
        pkt_valid_nxt = pkt_valid;
        parity_nxt    = parity;
        rd_ptr_nxt    = rd_ptr;
        len_nxt       = len;
        inj_nxt       = inj;
        done_nxt      = 1'b0;
        cmd_err_nxt   = 1'b0;
        buf_clr       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if ((buf_count == '0) || (addr == ADDR_INVALID)) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        data_nxt      = header;
                        pkt_valid_nxt = 1'b1;
                        parity_nxt    = header;
                        rd_ptr_nxt    = '0;
                        len_nxt       = buf_count;
`ifdef ROUTER_TX_ERR_INJECT_EN
                        inj_nxt       = err_inject;
`else
                        inj_nxt       = 1'b0;
`endif
                        state_nxt     = HDR;
                    end
                end
            end
            HDR, PLD: begin
                if (!busy) begin
                    if (rd_ptr != len) begin
                        data_nxt   = buf_rd_data;
                        parity_nxt = parity ^ buf_rd_data;
                        rd_ptr_nxt = rd_ptr + CNT_W'(1);
                        state_nxt  = PLD;
                    end else begin
                        data_nxt      = inj ? ~parity : parity;
                        pkt_valid_nxt = 1'b0;
                        state_nxt     = PAR;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    data_nxt  = '0;
                    buf_clr   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: scoreboard of expected {pkt_valid, data_out} bytes
// popped on every transfer edge, plus per-scenario checks of status outputs.
module tb_router_pkt_tx;
    import router_pkg::*;

    logic              clock = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_full;
    logic              start;
    logic [ADDR_W-1:0] addr;
`ifdef ROUTER_TX_ERR_INJECT_EN
    logic              err_inject;
`endif
    logic              tx_busy;
    logic              done;
    logic              cmd_err;
    logic              busy;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_out;

    router_pkt_tx dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .buf_count  (buf_count),
        .buf_full   (buf_full),
        .start      (start),
        .addr       (addr),
`ifdef ROUTER_TX_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .tx_busy    (tx_busy),
        .done       (done),
        .cmd_err    (cmd_err),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] sb[$];
    logic [7:0] model_buf[$];

    logic       stall_prev = 1'b0;
    logic [8:0] held;
    logic [8:0] exp_b;

    // Scoreboard monitor: a byte is consumed at the next rising edge when busy is low.
    always @(negedge clock) begin
        if (resetn && tx_busy) begin
            if (stall_prev) begin
                n_checks++;
                if ({pkt_valid, data_out} !== held)
                    $display("FAIL stall_hold: got %h required %h", {pkt_valid, data_out}, held);
                else
                    n_pass++;
            end
            if (!busy) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_byte: got %h required none", {pkt_valid, data_out});
                end else begin
                    exp_b = sb.pop_front();
                    if ({pkt_valid, data_out} !== exp_b)
                        $display("FAIL tx_byte: got %h required %h", {pkt_valid, data_out}, exp_b);
                    else
                        n_pass++;
                end
            end
            stall_prev = busy;
            held       = {pkt_valid, data_out};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (model_buf.size() < MAX_LEN) model_buf.push_back(b);
    endtask

    task automatic queue_packet(input logic [1:0] a, input logic inv);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = 8'((model_buf.size() << 2) | int'(a));
        par = hdr;
        sb.push_back({1'b1, hdr});
        foreach (model_buf[i]) begin
            sb.push_back({1'b1, model_buf[i]});
            par = par ^ model_buf[i];
        end
        sb.push_back({1'b0, inv ? ~par : par});
        model_buf.delete();
    endtask

    task automatic pulse_start(input logic [1:0] a);
        addr  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({pkt_valid, data_out, done, cmd_err, tx_busy, buf_full} !== 13'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {pkt_valid, data_out, done, cmd_err, tx_busy, buf_full});
        else
            n_pass++;
        n_checks++;
        if (buf_count !== 6'd0) $display("FAIL reset_count: got %0d required 0", buf_count);
        else n_pass++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        n_checks++;
        if (buf_count !== 6'd3) $display("FAIL basic_count: got %0d required 3", buf_count);
        else n_pass++;
        queue_packet(2'd1, 1'b0);
        pulse_start(2'd1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tx_busy !== 1'b1) $display("FAIL basic_busy%0d: got %b required 1", i, tx_busy);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({done, tx_busy, buf_count} !== {1'b1, 1'b0, 6'd0})
            $display("FAIL basic_done: got %b/%b/%0d required 1/0/0", done, tx_busy, buf_count);
        else
            n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b required 0", done);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL basic_drain: got %0d left required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_busy_stall;
        logic sched[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        queue_packet(2'd1, 1'b0);
        pulse_start(2'd1);
        for (int i = 0; i < 8; i++) begin
            busy = sched[i];
            n_checks++;
            if (tx_busy !== 1'b1) $display("FAIL stall_busy%0d: got %b required 1", i, tx_busy);
            else n_pass++;
            tick();
        end
        busy = 1'b0;
        n_checks++;
        if ({done, tx_busy} !== 2'b10)
            $display("FAIL stall_done: got %b%b required 10", done, tx_busy);
        else
            n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL stall_drain: got %0d left required 0", sb.size());
        else n_pass++;
        tick();
    endtask

    task automatic test_cmd_err;
        pulse_start(2'd1);
        n_checks++;
        if ({cmd_err, pkt_valid, tx_busy} !== 3'b100)
            $display("FAIL err_empty: got %b%b%b required 100", cmd_err, pkt_valid, tx_busy);
        else
            n_pass++;
        tick();
        n_checks++;
        if (cmd_err !== 1'b0) $display("FAIL err_pulse: got %b required 0", cmd_err);
        else n_pass++;

        load_byte(8'hA5);
        load_byte(8'h3C);
        pulse_start(2'd3);
        n_checks++;
        if ({cmd_err, pkt_valid, tx_busy, buf_count} !== {3'b100, 6'd2})
            $display("FAIL err_addr3: got %b%b%b/%0d required 100/2",
                     cmd_err, pkt_valid, tx_busy, buf_count);
        else
            n_pass++;

        wr_en   = 1'b1;
        wr_data = 8'h77;
        pulse_start(2'd3);
        wr_en   = 1'b0;
        n_checks++;
        if ({cmd_err, buf_count} !== {1'b1, 6'd2})
            $display("FAIL wr_start_collide: got %b/%0d required 1/2", cmd_err, buf_count);
        else
            n_pass++;

        queue_packet(2'd0, 1'b0);
        pulse_start(2'd0);
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        n_checks++;
        if ({done, buf_count} !== {1'b1, 6'd0})
            $display("FAIL wr_while_busy: got %b/%0d required 1/0", done, buf_count);
        else
            n_pass++;
        tick();
    endtask

    task automatic test_full;
        for (int i = 0; i < 64; i++) begin
            load_byte(8'($urandom_range(0, 255)));
            if (i == 61) begin
                n_checks++;
                if (buf_full !== 1'b0) $display("FAIL full_early: got %b required 0", buf_full);
                else n_pass++;
            end
            if (i == 62) begin
                n_checks++;
                if ({buf_full, buf_count} !== {1'b1, 6'd63})
                    $display("FAIL full_at63: got %b/%0d required 1/63", buf_full, buf_count);
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (buf_count !== 6'd63) $display("FAIL full_drop64: got %0d required 63", buf_count);
        else n_pass++;
        queue_packet(2'd2, 1'b0);
        pulse_start(2'd2);
        for (int i = 0; i < 65; i++) tick();
        n_checks++;
        if ({done, tx_busy, buf_full} !== 3'b100)
            $display("FAIL full_done: got %b%b%b required 100", done, tx_busy, buf_full);
        else
            n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL full_drain: got %0d left required 0", sb.size());
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        load_byte(8'h81);
        load_byte(8'h42);
        load_byte(8'h24);
        load_byte(8'h18);
        queue_packet(2'd0, 1'b0);
        pulse_start(2'd0);
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({pkt_valid, data_out, tx_busy} !== 10'h0)
            $display("FAIL reset_async: got %b/%h/%b required 0/00/0", pkt_valid, data_out, tx_busy);
        else
            n_pass++;
        sb.delete();
        tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if ({tx_busy, buf_count} !== 7'h0)
            $display("FAIL reset_release: got %b/%0d required 0/0", tx_busy, buf_count);
        else
            n_pass++;
        load_byte(8'h5A);
        load_byte(8'hF0);
        queue_packet(2'd2, 1'b0);
        pulse_start(2'd2);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if ({done, sb.size() == 0} !== 2'b11)
            $display("FAIL reset_recover: got done=%b left=%0d required 1/0", done, sb.size());
        else
            n_pass++;
        tick();
    endtask

`ifdef ROUTER_TX_ERR_INJECT_EN
    task automatic test_err_inject;
        load_byte(8'h05);
        queue_packet(2'd0, 1'b1);
        err_inject = 1'b1;
        pulse_start(2'd0);
        err_inject = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if ({done, sb.size() == 0} !== 2'b11)
            $display("FAIL inject_done: got done=%b left=%0d required 1/0", done, sb.size());
        else
            n_pass++;
        tick();
    endtask
`endif

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        start   = 1'b0;
        addr    = '0;
        busy    = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        test_reset();
        test_basic();
        test_busy_stall();
        test_cmd_err();
        test_full();
        test_reset_mid();
`ifdef ROUTER_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
